tlight_phased: RTL and testbench



---
 rtl/tlight_pkg.sv | 34 +++
 rtl/tlight_next_phase.sv | 32 +++
 rtl/tlight_phased.sv | 185 ++++++++++++++++++
 tb/tb_tlight_phased.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/tlight_pkg.sv
// Shared definitions for the phased traffic-light controller.
//   state_t  : controller state encoding, also driven on the state output.
//              FLASH exists only when TLIGHT_FLASH_EN is defined.
//   RED/YELLOW/GREEN/OFF : 3-bit lamp codes.
//   lamp_at  : places one phase's lamp code at bits [3k+2:3k] of a
//              maximum-width lights bus.
package tlight_pkg;

  localparam int unsigned MAX_PHASES = 8;

  typedef enum logic [2:0] {
    RESET           = 3'd0,
    READY_TO_GO     = 3'd1,
    GO              = 3'd2,
    PREPARE_TO_STOP = 3'd3,
    ALL_RED         = 3'd4
`ifdef TLIGHT_FLASH_EN
    , FLASH         = 3'd5
`endif
  } state_t;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;
  localparam logic [2:0] OFF    = 3'b000;

  function automatic logic [3*MAX_PHASES-1:0] lamp_at(input int unsigned k,
                                                      input logic [2:0] lamp);
    logic [3*MAX_PHASES-1:0] bus;
    bus = {{(3*MAX_PHASES-3){1'b0}}, lamp};
    return bus << (3*k);
  endfunction

endpackage

// File: rtl/tlight_next_phase.sv
// Round-robin phase picker.
//   cur_phase  : phase currently being served.
//   demand     : per-phase service request.
//   next_phase : first phase with demand scanning cur_phase+1 .. cur_phase
//                (wrapping); cur_phase+1 when no demand is present.
module tlight_next_phase #(
  parameter int unsigned N_PHASES = 2
) (
  input  logic [$clog2(N_PHASES)-1:0] cur_phase,
  input  logic [N_PHASES-1:0]         demand,
  output logic [$clog2(N_PHASES)-1:0] next_phase
);

  localparam int unsigned PW = $clog2(N_PHASES);

  // rot[j] is the demand of phase (cur_phase + 1 + j) mod N_PHASES
  logic [N_PHASES-1:0] rot;
  logic                found;

  always_comb begin
    rot        = N_PHASES'({demand, demand} >> (32'(cur_phase) + 32'd1));
    next_phase = PW'((32'(cur_phase) + 32'd1) % N_PHASES);
    found      = 1'b0;
    for (int unsigned j = 0; j < N_PHASES; j++) begin
      if (!found && rot[j]) begin
        next_phase = PW'((32'(cur_phase) + j + 32'd1) % N_PHASES);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tlight_phased.sv
// Parametrised multi-phase traffic-light controller.
// Sequences N_PHASES approaches through READY_TO_GO, GO, PREPARE_TO_STOP
// and an optional ALL_RED clearance, choosing the next phase by demand.
// Optional build macro TLIGHT_FLASH_EN adds a maintenance FLASH mode.
// Ports:
//   clock     : system clock, rising edge
//   reset     : synchronous active-high reset
//   demand    : per-phase service request, sampled at phase selection
//   flash_req : maintenance flash request (ignored without TLIGHT_FLASH_EN)
//   lights    : 3-bit lamp code per phase, phase k at [3k+2:3k]
//   cur_phase : phase being served
//   state     : current state_t
module tlight_phased
  import tlight_pkg::*;
#(
  parameter int unsigned N_PHASES    = 2,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned READY_CYC   = 3,
  parameter int unsigned GO_CYC      = 15,
  parameter int unsigned STOP_CYC    = 1,
  parameter int unsigned ALL_RED_CYC = 0,
  parameter int unsigned FLASH_HALF  = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_PHASES-1:0]         demand,
  input  logic                        flash_req,
  output logic [3*N_PHASES-1:0]       lights,
  output logic [$clog2(N_PHASES)-1:0] cur_phase,
  output logic [2:0]                  state
);

  localparam int unsigned PW = $clog2(N_PHASES);

  if (N_PHASES < 2 || N_PHASES > MAX_PHASES) begin : g_bad_phases
    $error("tlight_phased: N_PHASES must be within 2..8");
  end
  if (READY_CYC == 0 || GO_CYC == 0 || STOP_CYC == 0 || FLASH_HALF == 0) begin : g_bad_zero
    $error("tlight_phased: READY_CYC, GO_CYC, STOP_CYC and FLASH_HALF must be >= 1");
  end
  if (64'(READY_CYC) > (64'd1 << CNT_W) || 64'(GO_CYC) > (64'd1 << CNT_W) ||
      64'(STOP_CYC) > (64'd1 << CNT_W) || 64'(ALL_RED_CYC) > (64'd1 << CNT_W) ||
      64'(FLASH_HALF) > (64'd1 << CNT_W)) begin : g_bad_width
    $error("tlight_phased: a duration exceeds the dwell counter range");
  end

  localparam logic [CNT_W-1:0] READY_LD = CNT_W'(READY_CYC - 1);
  localparam logic [CNT_W-1:0] GO_LD    = CNT_W'(GO_CYC - 1);
  localparam logic [CNT_W-1:0] STOP_LD  = CNT_W'(STOP_CYC - 1);
  localparam logic [CNT_W-1:0] AR_LD    = CNT_W'((ALL_RED_CYC != 0) ? ALL_RED_CYC - 1 : 0);
`ifdef TLIGHT_FLASH_EN
  localparam logic [CNT_W-1:0] FLASH_LD = CNT_W'(FLASH_HALF - 1);
`endif

  state_t           state_q, state_d;
  logic [PW-1:0]    phase_q, phase_d, nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef TLIGHT_FLASH_EN
  logic             on_q, on_d;
`endif

  tlight_next_phase #(
    .N_PHASES(N_PHASES)
  ) u_next (
    .cur_phase (phase_q),
    .demand    (demand),
    .next_phase(nxt)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RESET;
      phase_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef TLIGHT_FLASH_EN
  always_ff @(posedge clock) begin
    if (reset) on_q <= 1'b0;
    else       on_q <= on_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q - CNT_W'(1);
`ifdef TLIGHT_FLASH_EN
    on_d    = on_q;
`endif
    unique case (state_q)
      RESET: begin
        state_d = READY_TO_GO;
        phase_d = '0;
        cnt_d   = READY_LD;
      end
      READY_TO_GO: if (cnt_q == '0) begin
        state_d = GO;
        cnt_d   = GO_LD;
      end
      GO: if (cnt_q == '0) begin
        state_d = PREPARE_TO_STOP;
        cnt_d   = STOP_LD;
      end
      PREPARE_TO_STOP: if (cnt_q == '0) begin
        if (ALL_RED_CYC != 0) begin
          state_d = ALL_RED;
          cnt_d   = AR_LD;
        end else begin
          state_d = READY_TO_GO;
          phase_d = nxt;
          cnt_d   = READY_LD;
        end
      end
      ALL_RED: if (cnt_q == '0) begin
        state_d = READY_TO_GO;
        phase_d = nxt;
        cnt_d   = READY_LD;
      end
`ifdef TLIGHT_FLASH_EN
      FLASH: if (cnt_q == '0) begin
        cnt_d = FLASH_LD;
        on_d  = !on_q;
      end
`endif
      default: begin
        state_d = RESET;
        phase_d = '0;
        cnt_d   = '0;
      end
    endcase
`ifdef TLIGHT_FLASH_EN
    // Flash overrides the normal sequence from any running state; the
    // FLASH case above only handles the yellow/off toggling while held.
    if (flash_req && state_q != RESET) begin
      state_d = FLASH;
      phase_d = phase_q;
      if (state_q != FLASH) begin
        cnt_d = FLASH_LD;
        on_d  = 1'b1;
      end
    end else if (state_q == FLASH) begin
      state_d = RESET;
      phase_d = '0;
      cnt_d   = '0;
    end
`endif
  end

  logic [3*MAX_PHASES-1:0] bus;
  logic [2:0]              lamp;

  always_comb begin
    bus  = '0;
    lamp = RED;
    for (int unsigned k = 0; k < N_PHASES; k++) begin
      lamp = RED;
      if (PW'(k) == phase_q) begin
        if (state_q == GO)
          lamp = GREEN;
        else if (state_q == READY_TO_GO || state_q == PREPARE_TO_STOP)
          lamp = YELLOW;
      end
`ifdef TLIGHT_FLASH_EN
      if (state_q == FLASH) lamp = on_q ? YELLOW : OFF;
`endif
      bus = bus | lamp_at(k, lamp);
    end
  end

  assign lights    = bus[3*N_PHASES-1:0];
  assign cur_phase = phase_q;
  assign state     = state_q;

  // Upper bus bits beyond N_PHASES and flash_req in the non-flash build
  // carry no information.
  logic unused_ok;
  assign unused_ok = ^{bus, flash_req};

endmodule

// File: tb/tb_tlight_phased.sv
// Randomised scoreboard bench for tlight_phased: two instances (default
// two-phase timing, and a four-phase build with all-red clearance) share
// random demand, reset pulses and flash requests. A service-level model
// expands each phase service into its per-cycle expectation.
module tb_tlight_phased;
  import tlight_pkg::*;

  typedef struct packed {
    state_t     st;
    logic [2:0] ph;
    logic       on;
  } exp_t;

  localparam int unsigned NP[2] = '{2, 4};
  localparam int unsigned RC[2] = '{3, 2};
  localparam int unsigned GC[2] = '{15, 5};
  localparam int unsigned SC[2] = '{1, 2};
  localparam int unsigned AC[2] = '{0, 2};
  localparam int unsigned FH[2] = '{4, 3};
  localparam int unsigned NCYC  = 4000;

  logic        clock = 1'b0;
  logic        reset;
  logic        flash_req;
  logic [7:0]  demand;
  logic [5:0]  l0;
  logic [0:0]  p0;
  logic [2:0]  s0;
  logic [11:0] l1;
  logic [1:0]  p1;
  logic [2:0]  s1;

  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t        cur[2];
  exp_t        future[2][$];
  exp_t        exp_q[2][$];
  int unsigned fc[2];

  always #5 clock = ~clock;

  tlight_phased #(
    .N_PHASES(2), .CNT_W(8), .READY_CYC(3), .GO_CYC(15), .STOP_CYC(1),
    .ALL_RED_CYC(0), .FLASH_HALF(4)
  ) u_def (
    .clock(clock), .reset(reset), .demand(demand[1:0]), .flash_req(flash_req),
    .lights(l0), .cur_phase(p0), .state(s0)
  );

  tlight_phased #(
    .N_PHASES(4), .CNT_W(4), .READY_CYC(2), .GO_CYC(5), .STOP_CYC(2),
    .ALL_RED_CYC(2), .FLASH_HALF(3)
  ) u_ar (
    .clock(clock), .reset(reset), .demand(demand[3:0]), .flash_req(flash_req),
    .lights(l1), .cur_phase(p1), .state(s1)
  );

  function automatic logic [23:0] exp_lights(int unsigned i, exp_t e);
    logic [23:0] v;
    logic [2:0]  c;
    v = '0;
    for (int unsigned k = 0; k < NP[i]; k++) begin
      c = 3'b100;
      if (k == e.ph) begin
        if (e.st == GO) c = 3'b001;
        else if (e.st == READY_TO_GO || e.st == PREPARE_TO_STOP) c = 3'b010;
      end
`ifdef TLIGHT_FLASH_EN
      if (e.st == FLASH) c = e.on ? 3'b010 : 3'b000;
`endif
      v = v | (24'(c) << (3*k));
    end
    return v;
  endfunction

  function automatic int unsigned pick(int unsigned i, int unsigned p, logic [7:0] d);
    for (int unsigned s = 1; s <= NP[i]; s++)
      if (d[3'((p + s) % NP[i])]) return (p + s) % NP[i];
    return (p + 1) % NP[i];
  endfunction

  task automatic expand(int unsigned i, int unsigned p);
    repeat (RC[i]) future[i].push_back('{READY_TO_GO, 3'(p), 1'b0});
    repeat (GC[i]) future[i].push_back('{GO, 3'(p), 1'b0});
    repeat (SC[i]) future[i].push_back('{PREPARE_TO_STOP, 3'(p), 1'b0});
    repeat (AC[i]) future[i].push_back('{ALL_RED, 3'(p), 1'b0});
  endtask

  // Advance the model across the coming edge using the inputs now driven.
  task automatic step(int unsigned i);
    exp_t c;
    c = cur[i];
    if (reset) begin
      future[i].delete();
      cur[i] = '{RESET, 3'd0, 1'b0};
      return;
    end
`ifdef TLIGHT_FLASH_EN
    if (flash_req && c.st != RESET) begin
      future[i].delete();
      fc[i]  = (c.st == FLASH) ? fc[i] + 1 : 0;
      cur[i] = '{FLASH, c.ph, ((fc[i] / FH[i]) % 2) == 0};
      return;
    end
    if (c.st == FLASH) begin
      cur[i] = '{RESET, 3'd0, 1'b0};
      return;
    end
`endif
    if (c.st == RESET) expand(i, 0);
    else if (future[i].size() == 0) expand(i, pick(i, c.ph, demand));
    cur[i] = future[i].pop_front();
  endtask

  task automatic check(string name, int unsigned i, logic [23:0] act, logic [23:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s inst%0d actual=%h required=%h t=%0t", name, i, act, req, $time);
    end
  endtask

  always @(negedge clock) begin
    for (int unsigned i = 0; i < 2; i++) begin
      if (exp_q[i].size() != 0) begin
        exp_t e;
        e = exp_q[i].pop_front();
        check("state", i, (i == 0) ? 24'(s0) : 24'(s1), 24'(e.st));
        check("cur_phase", i, (i == 0) ? 24'(p0) : 24'(p1), 24'(e.ph));
        check("lights", i, (i == 0) ? 24'(l0) : 24'(l1), exp_lights(i, e));
      end
    end
  end

  initial begin
    int unsigned flash_left;
    int unsigned guard;
    flash_left = 0;
    reset      = 1'b1;
    flash_req  = 1'b0;
    demand     = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      cur[i] = '{RESET, 3'd0, 1'b0};
      fc[i]  = 0;
    end
    repeat (3) @(posedge clock);
    #1;
    for (int unsigned cyc = 0; cyc < NCYC; cyc++) begin
      for (int unsigned i = 0; i < 2; i++) exp_q[i].push_back(cur[i]);
      // First stretch: clean fixed-time run with no demand, reset or flash.
      if (cyc < 200) begin
        reset     = 1'b0;
        demand    = '0;
        flash_req = 1'b0;
      end else begin
        reset = ($urandom_range(0, 199) == 0);
        case ($urandom_range(0, 3))
          0:       demand = '0;
          1:       demand = 8'd1 << $urandom_range(0, 3);
          default: demand = 8'($urandom);
        endcase
        if (flash_left != 0) begin
          flash_left--;
          flash_req = 1'b1;
        end else begin
          flash_req = 1'b0;
          if ($urandom_range(0, 149) == 0) flash_left = $urandom_range(4, 15);
        end
      end
      for (int unsigned i = 0; i < 2; i++) step(i);
      @(posedge clock);
      #1;
    end
    guard = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && guard < 10) begin
      @(negedge clock);
      guard++;
    end
    #1;
    if (exp_q[0].size() != 0 || exp_q[1].size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q[0].size() + exp_q[1].size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
